// File: rtl/cacheline_adaptor_pkg.sv
// Shared cache geometry: line/beat widths, derived counts and line/beat types.
package cacheline_adaptor_pkg;

  localparam int LINE_W   = 256;
  localparam int BURST_W  = 64;
  localparam int ADDR_W   = 32;
  localparam int BEATS    = LINE_W / BURST_W;
  localparam int OFFSET_W = $clog2(LINE_W / 8);
  localparam int CNT_W    = $clog2(BEATS);

  typedef logic [BURST_W-1:0]    beat_t;
  // Beat 0 occupies the least significant BURST_W bits of the line.
  typedef beat_t [BEATS-1:0]     line_t;

endpackage

// File: rtl/cacheline_adaptor_if.sv
// Cache-side line request and memory-side burst signals of the adaptor.
interface cacheline_adaptor_if;
  import cacheline_adaptor_pkg::*;

  // cache side
  logic              read_i;
  logic              write_i;
  logic [ADDR_W-1:0] address_i;
  line_t             line_i;
  line_t             line_o;
  logic              resp_o;
  // memory side
  logic [ADDR_W-1:0] address_o;
  logic              read_o;
  logic              write_o;
  beat_t             burst_o;
  beat_t             burst_i;
  logic              resp_i;

  // Adaptor view.
  modport slave (
    input  read_i, write_i, address_i, line_i, burst_i, resp_i,
    output line_o, resp_o, address_o, read_o, write_o, burst_o
  );

  // Environment view (cache + memory model).
  modport master (
    output read_i, write_i, address_i, line_i, burst_i, resp_i,
    input  line_o, resp_o, address_o, read_o, write_o, burst_o
  );

endinterface

// File: rtl/cacheline_adaptor.sv
// Converts one cacheline read/write into a BEATS-long burst on the memory port.
module cacheline_adaptor
  import cacheline_adaptor_pkg::*;
(
  input logic             clk,
  input logic             rst_n,
  cacheline_adaptor_if.slave bus
);

  typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} state_t;

  state_t                     state, state_nxt;
  logic [CNT_W-1:0]           cnt;
  line_t                      line_q;
  // Offset bits are always cleared on the way out, so only the line index is kept.
  logic [ADDR_W-OFFSET_W-1:0] addr_q;

  wire last_beat = bus.resp_i && (cnt == CNT_W'(BEATS - 1));

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Request latch, beat counter and line buffer; cnt wraps to 0 on the last beat.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt    <= '0;
      line_q <= '0;
      addr_q <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.read_i) begin
            addr_q <= bus.address_i[ADDR_W-1:OFFSET_W];
            cnt    <= '0;
          end else if (bus.write_i) begin
            addr_q <= bus.address_i[ADDR_W-1:OFFSET_W];
            line_q <= bus.line_i;
            cnt    <= '0;
          end
        end
        READ: begin
          if (bus.resp_i) begin
            line_q[cnt] <= bus.burst_i;
            cnt         <= cnt + 1'b1;
          end
        end
        WRITE: begin
          if (bus.resp_i) cnt <= cnt + 1'b1;
        end
        default: ;
      endcase
    end
  end

  // Next state and outputs; outputs depend only on registered state.
  always_comb begin
    state_nxt     = state;
    bus.read_o    = 1'b0;
    bus.write_o   = 1'b0;
    bus.resp_o    = 1'b0;
    bus.burst_o   = '0;
    bus.address_o = '0;
    case (state)
      IDLE: begin
        if      (bus.read_i)  state_nxt = READ;
        else if (bus.write_i) state_nxt = WRITE;
      end
      READ: begin
        bus.read_o    = 1'b1;
        bus.address_o = {addr_q, {OFFSET_W{1'b0}}};
        if (last_beat) state_nxt = DONE;
      end
      WRITE: begin
        bus.write_o   = 1'b1;
        bus.burst_o   = line_q[cnt];
        bus.address_o = {addr_q, {OFFSET_W{1'b0}}};
        if (last_beat) state_nxt = DONE;
      end
      DONE: begin
        bus.resp_o = 1'b1;
        state_nxt  = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign bus.line_o = line_q;

endmodule
